// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the SDRAM burst scheduler and the controller wrapper.
// Command encoding matches the as4c4m16sa_controller command port.
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  localparam int SDRAM_ADDR_WIDTH   = 22;
  localparam int SDRAM_DATA_WIDTH   = 16;
  localparam int SDRAM_BURST_LENGTH = 8;
  localparam int SDRAM_CMD_WIDTH    = 2;

  // Index width that stays legal (>=1 bit) for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_burst_scheduler_rr_picker.sv
// Round-robin picker: first requester at or after i_start, wrapping modulo N.
module rr_picker
  import sdram_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [IW-1:0] o_grant,
  output logic          o_any
);

  logic [IW-1:0] w_rot [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign w_rot[gi] = IW'((32'(i_start) + gi) % N);
  end

  // Descending scan so the candidate closest to i_start is assigned last and wins.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[w_rot[k]]) begin
        o_grant = w_rot[k];
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_burst_scheduler.sv
// Schedules fixed-length SDRAM bursts between write and read channel FIFOs, one ring region per channel.
// Optional macro STARVATION_GUARD_EN forces a read after MAX_WRITE_RUN consecutive write bursts.
module sdram_burst_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int NUM_WR       = 2,
  parameter int NUM_RD       = 2,
  parameter int BURST_LENGTH = SDRAM_BURST_LENGTH,
  parameter int ADDR_WIDTH   = SDRAM_ADDR_WIDTH,
  parameter int REGION_SIZE  = 153600
`ifdef STARVATION_GUARD_EN
  ,
  parameter int MAX_WRITE_RUN = 4
`endif
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_WR-1:0]                     wr_burst_ready,
  input  logic [NUM_WR-1:0][SDRAM_DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WR-1:0]                     wr_ack,
  input  logic [NUM_WR-1:0]                     wr_frame_reset,
  input  logic [NUM_RD-1:0]                     rd_space,
  output logic [NUM_RD-1:0]                     rd_valid,
  output logic [SDRAM_DATA_WIDTH-1:0]           rd_data,
  input  logic [NUM_RD-1:0]                     rd_frame_reset,
  output logic [SDRAM_CMD_WIDTH-1:0]            command,
  output logic [ADDR_WIDTH-1:0]                 data_address,
  output logic [SDRAM_DATA_WIDTH-1:0]           data_write,
  input  logic                                  data_write_done,
  input  logic [SDRAM_DATA_WIDTH-1:0]           data_read,
  input  logic                                  data_read_valid
);

  // NUM_RD <= NUM_WR, so one grant register wide enough for writes serves both classes.
  localparam int GW = idx_width(NUM_WR);
  localparam int RW = idx_width(NUM_RD);
  localparam int BW = idx_width(BURST_LENGTH);
  localparam logic [BW-1:0]         LAST_BEAT  = BW'(BURST_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BURST_LENGTH);
  localparam logic [ADDR_WIDTH:0]   STEP_EXT   = (ADDR_WIDTH + 1)'(BURST_LENGTH);
  localparam logic [ADDR_WIDTH:0]   REGION_END = (ADDR_WIDTH + 1)'(REGION_SIZE);

  state_t          r_state, w_state_next;
  cmd_t            r_cmd, w_cmd_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [GW-1:0]   r_grant, w_grant_next;
  logic [BW-1:0]   r_beat, w_beat_next;
  logic [GW-1:0]   r_wr_start, w_wr_start_next;
  logic [RW-1:0]   r_rd_start, w_rd_start_next;
  logic            w_wr_end, w_rd_end;

  logic [GW-1:0]   w_wr_pick;
  logic [RW-1:0]   w_rd_pick;
  logic            w_wr_any, w_rd_any;
  logic            w_guard;

  logic [ADDR_WIDTH-1:0] w_region_base [NUM_WR];
  logic [ADDR_WIDTH-1:0] w_wr_ptr [NUM_WR];
  logic [ADDR_WIDTH-1:0] w_rd_ptr [NUM_RD];
  logic [ADDR_WIDTH-1:0] w_wr_ptr_eff, w_rd_ptr_eff;

  rr_picker #(.N(NUM_WR), .IW(GW)) u_wr_pick (
    .i_req   (wr_burst_ready),
    .i_start (r_wr_start),
    .o_grant (w_wr_pick),
    .o_any   (w_wr_any)
  );

  rr_picker #(.N(NUM_RD), .IW(RW)) u_rd_pick (
    .i_req   (rd_space),
    .i_start (r_rd_start),
    .o_grant (w_rd_pick),
    .o_any   (w_rd_any)
  );

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_base
    assign w_region_base[gi] = ADDR_WIDTH'(gi * REGION_SIZE);
  end

  // A frame reset arriving in the grant cycle restarts the burst at the region start.
  assign w_wr_ptr_eff = wr_frame_reset[w_wr_pick] ? '0 : w_wr_ptr[w_wr_pick];
  assign w_rd_ptr_eff = rd_frame_reset[w_rd_pick] ? '0 : w_rd_ptr[w_rd_pick];

`ifdef STARVATION_GUARD_EN
  localparam int RUN_W = idx_width(MAX_WRITE_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_WRITE_RUN);

  logic [RUN_W-1:0] r_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= '0;
    end else if (w_rd_end) begin
      r_run <= '0;
    end else if (w_wr_end && (r_run != RUN_MAX)) begin
      r_run <= r_run + 1'b1;
    end
  end

  assign w_guard = (r_run == RUN_MAX) && w_rd_any;
`else
  assign w_guard = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cmd      <= CMD_IDLE;
      r_addr     <= '0;
      r_grant    <= '0;
      r_beat     <= '0;
      r_wr_start <= '0;
      r_rd_start <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cmd      <= w_cmd_next;
      r_addr     <= w_addr_next;
      r_grant    <= w_grant_next;
      r_beat     <= w_beat_next;
      r_wr_start <= w_wr_start_next;
      r_rd_start <= w_rd_start_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = r_cmd;
    w_addr_next     = r_addr;
    w_grant_next    = r_grant;
    w_beat_next     = r_beat;
    w_wr_start_next = r_wr_start;
    w_rd_start_next = r_rd_start;
    w_wr_end        = 1'b0;
    w_rd_end        = 1'b0;
    case (r_state)
      IDLE: begin
        w_beat_next = '0;
        if (w_wr_any && !w_guard) begin
          w_state_next    = WRITE;
          w_cmd_next      = CMD_WRITE;
          w_grant_next    = w_wr_pick;
          w_addr_next     = w_region_base[w_wr_pick] + w_wr_ptr_eff;
          w_wr_start_next = (w_wr_pick == GW'(NUM_WR - 1)) ? '0 : w_wr_pick + 1'b1;
        end else if (w_rd_any) begin
          w_state_next    = READ;
          w_cmd_next      = CMD_READ;
          w_grant_next    = GW'(w_rd_pick);
          w_addr_next     = w_region_base[w_rd_pick] + w_rd_ptr_eff;
          w_rd_start_next = (w_rd_pick == RW'(NUM_RD - 1)) ? '0 : w_rd_pick + 1'b1;
        end
      end
      WRITE: begin
        if (data_write_done) begin
          w_beat_next = r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_wr_end     = 1'b1;
            w_state_next = IDLE;
            w_cmd_next   = CMD_IDLE;
            w_addr_next  = '0;
          end
        end
      end
      READ: begin
        if (data_read_valid) begin
          w_beat_next = r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_rd_end     = 1'b1;
            w_state_next = IDLE;
            w_cmd_next   = CMD_IDLE;
            w_addr_next  = '0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cmd_next   = CMD_IDLE;
        w_addr_next  = '0;
      end
    endcase
  end

  // Per-channel ring pointers; a frame reset during the channel's own burst is deferred to burst end.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_pend;
    logic                  w_busy, w_wrap;

    assign w_busy = (r_state == WRITE) && (r_grant == GW'(gi));
    assign w_wrap = (({1'b0, r_ptr}) + STEP_EXT) == REGION_END;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_ptr  <= '0;
        r_pend <= 1'b0;
      end else if (w_busy) begin
        if (w_wr_end) begin
          r_ptr  <= (r_pend || wr_frame_reset[gi] || w_wrap) ? '0 : r_ptr + STEP;
          r_pend <= 1'b0;
        end else if (wr_frame_reset[gi]) begin
          r_pend <= 1'b1;
        end
      end else if (wr_frame_reset[gi]) begin
        r_ptr <= '0;
      end
    end

    assign w_wr_ptr[gi] = r_ptr;
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_pend;
    logic                  w_busy, w_wrap;

    assign w_busy = (r_state == READ) && (r_grant == GW'(gi));
    assign w_wrap = (({1'b0, r_ptr}) + STEP_EXT) == REGION_END;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_ptr  <= '0;
        r_pend <= 1'b0;
      end else if (w_busy) begin
        if (w_rd_end) begin
          r_ptr  <= (r_pend || rd_frame_reset[gi] || w_wrap) ? '0 : r_ptr + STEP;
          r_pend <= 1'b0;
        end else if (rd_frame_reset[gi]) begin
          r_pend <= 1'b1;
        end
      end else if (rd_frame_reset[gi]) begin
        r_ptr <= '0;
      end
    end

    assign w_rd_ptr[gi] = r_ptr;
  end

  always_comb begin
    wr_ack     = '0;
    rd_valid   = '0;
    data_write = '0;
    if (r_state == WRITE) begin
      wr_ack[r_grant] = data_write_done;
      data_write      = wr_data[r_grant];
    end
    if (r_state == READ) begin
      rd_valid[r_grant] = data_read_valid;
    end
  end

  assign rd_data      = data_read;
  assign command      = r_cmd;
  assign data_address = r_addr;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Bench for sdram_burst_scheduler: burst-level reference model checked every cycle plus directed scenarios.
// Honors STARVATION_GUARD_EN when deciding what the scheduler must grant.
`timescale 1ns/1ps
module tb_sdram_burst_scheduler;

  localparam int NW  = 2;
  localparam int NR  = 2;
  localparam int BL  = 8;
  localparam int AW  = 22;
  localparam int RS  = 48;
  localparam int MWR = 4;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NW-1:0]         wr_burst_ready = '0;
  logic [NW-1:0][15:0]   wr_data = '0;
  logic [NW-1:0]         wr_ack;
  logic [NW-1:0]         wr_frame_reset = '0;
  logic [NR-1:0]         rd_space = '0;
  logic [NR-1:0]         rd_valid;
  logic [15:0]           rd_data;
  logic [NR-1:0]         rd_frame_reset = '0;
  logic [1:0]            command;
  logic [AW-1:0]         data_address;
  logic [15:0]           data_write;
  logic                  data_write_done = 1'b0;
  logic [15:0]           data_read = '0;
  logic                  data_read_valid = 1'b0;

  always #5 clk = ~clk;

  sdram_burst_scheduler #(
    .NUM_WR(NW), .NUM_RD(NR), .BURST_LENGTH(BL), .ADDR_WIDTH(AW), .REGION_SIZE(RS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_burst_ready(wr_burst_ready), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_frame_reset(wr_frame_reset),
    .rd_space(rd_space), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_frame_reset(rd_frame_reset),
    .command(command), .data_address(data_address), .data_write(data_write),
    .data_write_done(data_write_done), .data_read(data_read), .data_read_valid(data_read_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Burst log and beat counters filled by the compare process.
  int log_cmd[$];
  int log_addr[$];
  int ack_cnt[NW];
  int rv_cnt[NR];
  bit gap_mode = 1'b0;

  // Controller emulation: consumes/produces one word per cycle (or every other cycle in gap mode).
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      wr_data[0]      = 16'h1000 + 16'(cyc);
      wr_data[1]      = 16'h2000 + 16'(cyc);
      data_read       = 16'h3000 + 16'(cyc);
      data_write_done = (command == 2'd1) && (!gap_mode || cyc[0]);
      data_read_valid = (command == 2'd2) && (!gap_mode || cyc[0]);
    end
  end

  function automatic int rr(input logic [7:0] req, input int n, input int start);
    for (int k = 0; k < n; k++) begin
      int c = (start + k) % n;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Reference model at burst level plus per-cycle compare.
  initial begin
    bit   m_busy, m_pend, guard;
    int   m_cmd, m_ch, m_addr, m_beats, m_wst, m_rst, m_run, wc, rc;
    int   m_wptr[NW];
    int   m_rptr[NR];
    logic [1:0] prev_cmd;
    m_busy = 0; m_pend = 0; m_cmd = 0; m_ch = 0; m_addr = 0; m_beats = 0;
    m_wst = 0; m_rst = 0; m_run = 0; prev_cmd = 2'd0;
    foreach (m_wptr[i]) m_wptr[i] = 0;
    foreach (m_rptr[i]) m_rptr[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rst_command", command, 0);
        check("rst_address", data_address, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_rd_valid", rd_valid, 0);
        m_busy = 0; m_pend = 0; m_cmd = 0; m_beats = 0;
        m_wst = 0; m_rst = 0; m_run = 0; prev_cmd = 2'd0;
        foreach (m_wptr[i]) m_wptr[i] = 0;
        foreach (m_rptr[i]) m_rptr[i] = 0;
      end else begin
        check("command", command, m_busy ? m_cmd : 0);
        check("address", data_address, m_busy ? m_addr : 0);
        check("wr_ack", wr_ack, (m_busy && m_cmd == 1 && data_write_done) ? (1 << m_ch) : 0);
        check("rd_valid", rd_valid, (m_busy && m_cmd == 2 && data_read_valid) ? (1 << m_ch) : 0);
        check("rd_data", rd_data, data_read);
        if (m_busy && m_cmd == 1) check("data_write", data_write, wr_data[m_ch]);
        if (command != 2'd0 && prev_cmd == 2'd0) begin
          log_cmd.push_back(int'(command));
          log_addr.push_back(int'(data_address));
        end
        prev_cmd = command;
        for (int i = 0; i < NW; i++) ack_cnt[i] += int'(wr_ack[i]);
        for (int i = 0; i < NR; i++) rv_cnt[i] += int'(rd_valid[i]);

        for (int i = 0; i < NW; i++)
          if (wr_frame_reset[i]) begin
            if (m_busy && m_cmd == 1 && m_ch == i) m_pend = 1; else m_wptr[i] = 0;
          end
        for (int i = 0; i < NR; i++)
          if (rd_frame_reset[i]) begin
            if (m_busy && m_cmd == 2 && m_ch == i) m_pend = 1; else m_rptr[i] = 0;
          end

        if (m_busy) begin
          if ((m_cmd == 1 && data_write_done) || (m_cmd == 2 && data_read_valid)) begin
            m_beats++;
            if (m_beats == BL) begin
              if (m_cmd == 1) begin
                m_wptr[m_ch] = m_pend ? 0 : (m_wptr[m_ch] + BL) % RS;
                if (m_run < MWR) m_run++;
              end else begin
                m_rptr[m_ch] = m_pend ? 0 : (m_rptr[m_ch] + BL) % RS;
                m_run = 0;
              end
              m_busy = 0;
              m_pend = 0;
            end
          end
        end else begin
          guard = 0;
`ifdef STARVATION_GUARD_EN
          guard = (m_run >= MWR) && (rd_space != '0);
`endif
          wc = rr(8'(wr_burst_ready), NW, m_wst);
          rc = rr(8'(rd_space), NR, m_rst);
          if (wc >= 0 && !guard) begin
            m_busy = 1; m_cmd = 1; m_ch = wc; m_beats = 0; m_pend = 0;
            m_addr = wc * RS + m_wptr[wc];
            m_wst  = (wc + 1) % NW;
          end else if (rc >= 0) begin
            m_busy = 1; m_cmd = 2; m_ch = rc; m_beats = 0; m_pend = 0;
            m_addr = rc * RS + m_rptr[rc];
            m_rst  = (rc + 1) % NR;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n        = 1'b0;
    wr_burst_ready = '0;
    rd_space       = '0;
    wr_frame_reset = '0;
    rd_frame_reset = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    log_cmd.delete();
    log_addr.delete();
    foreach (ack_cnt[i]) ack_cnt[i] = 0;
    foreach (rv_cnt[i]) rv_cnt[i] = 0;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_cmd.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, log_cmd.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (command != 2'd0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, command, 0);
  endtask

  initial begin
    int reads;

    // 1: single write channel, one-cycle grant latency, 8 acks, pointer advanced to 8
    do_reset();
    wr_burst_ready = 2'b01;
    @(posedge clk);
    #1;
    check("t1_cmd_latency", command, 1);
    check("t1_addr", data_address, 0);
    wr_burst_ready = 2'b00;
    wait_idle(30, "t1_idle");
    check("t1_acks_ch0", ack_cnt[0], 8);
    check("t1_acks_ch1", ack_cnt[1], 0);
    wr_burst_ready = 2'b01;
    wait_log(2, 10, "t1_second");
    wr_burst_ready = 2'b00;
    wait_idle(30, "t1_idle2");
    check("t1_next_addr", log_addr[1], 8);
    $display("t1 single write: bursts=%0d acks0=%0d", log_cmd.size(), ack_cnt[0]);

    // 2: both write channels ready, round-robin alternation
    do_reset();
    wr_burst_ready = 2'b11;
    wait_log(4, 60, "t2_bursts");
    wr_burst_ready = 2'b00;
    wait_idle(30, "t2_idle");
    check("t2_addr0", log_addr[0], 0);
    check("t2_addr1", log_addr[1], 48);
    check("t2_addr2", log_addr[2], 8);
    check("t2_addr3", log_addr[3], 56);
    $display("t2 rr writes: %0d %0d %0d %0d", log_addr[0], log_addr[1], log_addr[2], log_addr[3]);

    // 3: read on channel 1 only, with gaps in data_read_valid
    do_reset();
    gap_mode = 1'b1;
    rd_space = 2'b10;
    wait_log(1, 10, "t3_start");
    rd_space = 2'b00;
    wait_idle(40, "t3_idle");
    gap_mode = 1'b0;
    check("t3_cmd", log_cmd[0], 2);
    check("t3_addr", log_addr[0], 48);
    check("t3_rv1", rv_cnt[1], 8);
    check("t3_rv0", rv_cnt[0], 0);
    $display("t3 read ch1: addr=%0d rv1=%0d rv0=%0d", log_addr[0], rv_cnt[1], rv_cnt[0]);

    // 4: ring wrap after REGION/BL bursts
    do_reset();
    wr_burst_ready = 2'b01;
    wait_log(7, 120, "t4_bursts");
    wr_burst_ready = 2'b00;
    wait_idle(30, "t4_idle");
    check("t4_last_before_wrap", log_addr[5], 40);
    check("t4_wrapped", log_addr[6], 0);
    $display("t4 wrap: addr5=%0d addr6=%0d", log_addr[5], log_addr[6]);

    // 5: frame reset mid-burst is deferred, burst still completes
    do_reset();
    wr_burst_ready = 2'b01;
    wait_log(1, 10, "t5_start");
    repeat (2) @(posedge clk);
    #1;
    wr_frame_reset = 2'b01;
    @(posedge clk);
    #1;
    wr_frame_reset = 2'b00;
    wait_log(2, 30, "t5_second");
    wr_burst_ready = 2'b00;
    wait_idle(30, "t5_idle");
    check("t5_first_acks", ack_cnt[0], 16);
    check("t5_restart_addr", log_addr[1], 0);
    $display("t5 frame reset: addr1=%0d acks0=%0d", log_addr[1], ack_cnt[0]);

    // 6: writes saturating with read space pending
    do_reset();
    wr_burst_ready = 2'b11;
    rd_space       = 2'b01;
    wait_log(10, 200, "t6_bursts");
    wr_burst_ready = 2'b00;
    rd_space       = 2'b00;
    wait_idle(30, "t6_idle");
    reads = 0;
    foreach (log_cmd[i]) if (log_cmd[i] == 2) reads++;
`ifdef STARVATION_GUARD_EN
    check("t6_reads", reads, 2);
    check("t6_read_pos4", log_cmd[4], 2);
    check("t6_read_addr4", log_addr[4], 0);
    check("t6_read_pos9", log_cmd[9], 2);
    check("t6_read_addr9", log_addr[9], 8);
`else
    check("t6_reads", reads, 0);
    check("t6_addr4", log_addr[4], 16);
`endif
    $display("t6 write run: bursts=%0d reads=%0d", log_cmd.size(), reads);

    // 7: reset mid-burst aborts immediately and clears pointers
    do_reset();
    wr_burst_ready = 2'b01;
    wait_log(2, 30, "t7_start");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("t7_cmd_in_reset", command, 0);
    check("t7_addr_in_reset", data_address, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    log_cmd.delete();
    log_addr.delete();
    wait_log(1, 10, "t7_restart");
    wr_burst_ready = 2'b00;
    wait_idle(30, "t7_idle");
    check("t7_addr_after_reset", log_addr[0], 0);
    $display("t7 reset mid-burst: addr=%0d", log_addr[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
